pcie_video_unpack: RTL and testbench

- Host-to-display counterpart of the capture-to-PCIe path.
- Accepts 128-bit words written by the PCIe DMA engine, buffers them, and unpacks each word into eight 16-bit RGB565 pixels.
- Regenerates raster timing (vsync/href/de) so a display or loopback sink sees the same stream format the capture side consumes.
- Sits between the DMA write-data interface and the video output pipeline, in the pclk_div2 domain.

---
 rtl/pcie_video_pkg.sv | 29 ++
 rtl/pcie_video_word_fifo.sv | 64 ++++++
 rtl/pcie_video_unpack.sv | 177 +++++++++++++++++
 tb/tb_pcie_video_unpack.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pcie_video_pkg.sv
// rtl/pcie_video_pkg.sv - shared types, default raster constants and width helpers for the video unpacker
package pcie_video_pkg;

    localparam int LANES  = 8;
    localparam int LANE_W = $clog2(LANES);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int total(input int active, input int blank);
        return active + blank;
    endfunction

    function automatic int words_per_line(input int h_active);
        return h_active / LANES;
    endfunction

    // Default 720p timing; instances with other parameters derive their own via the helpers above.
    localparam int H_TOTAL        = total(1280, 370);
    localparam int V_TOTAL        = total(720, 30);
    localparam int WORDS_PER_LINE = words_per_line(1280);

endpackage

// File: rtl/pcie_video_word_fifo.sv
// rtl/pcie_video_word_fifo.sv - synchronous word FIFO with occupancy count and head presented from storage flops
module pcie_video_word_fifo
    import pcie_video_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 128,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = cnt_w(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/pcie_video_unpack.sv
// rtl/pcie_video_unpack.sv - buffers 128-bit DMA words and replays them as RGB565 pixels with regenerated raster timing
module pcie_video_unpack
    import pcie_video_pkg::*;
#(
    parameter int          H_ACTIVE   = 1280,
    parameter int          H_BLANK    = 370,
    parameter int          V_ACTIVE   = 720,
    parameter int          V_BLANK    = 30,
    parameter int          VS_LINES   = 5,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] FILL       = 16'hCCCC
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         vsync_out,
    output logic         href_out,
    output logic         de_out,
    output logic [15:0]  data_out,
    output logic [15:0]  underrun_cnt,
    output logic [15:0]  frame_cnt,
    output logic         busy
);

    localparam int H_TOT = total(H_ACTIVE, H_BLANK);
    localparam int V_TOT = total(V_ACTIVE, V_BLANK);
    localparam int H_W   = cnt_w(H_TOT);
    localparam int V_W   = cnt_w(V_TOT);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [H_W-1:0]   H_LAST      = H_W'(H_TOT - 1);
    localparam logic [H_W-1:0]   H_ACT_END   = H_W'(H_ACTIVE);
    localparam logic [V_W-1:0]   V_LAST      = V_W'(V_TOT - 1);
    localparam logic [V_W-1:0]   V_ACT_START = V_W'(V_BLANK);
    localparam logic [V_W-1:0]   V_VS_END    = V_W'(VS_LINES);
    localparam logic [CNT_W-1:0] DEPTH_C     = CNT_W'(FIFO_DEPTH);

    state_e             state_q, state_d;
    logic [H_W-1:0]     h_q, h_d;
    logic [V_W-1:0]     v_q, v_d;
    logic [15:0]        frame_q, frame_d;
    logic [15:0]        under_q, under_d;
    logic               vsync_q, vsync_d;
    logic               href_q, href_d;
    logic [LANE_W-1:0]  lane_q, lane_d;
    logic [127:0]       shift_q, shift_d;
    logic               fill_q, fill_d;

    logic               flush;
    logic               push;
    logic               pop;
    logic               fifo_empty;
    logic [127:0]       fifo_head;
    logic [CNT_W-1:0]   fifo_count;

    assign fifo_empty = (fifo_count == '0);
    assign in_ready   = (state_q == RUN) && (fifo_count < DEPTH_C);
    assign push       = in_valid && in_ready;
    assign pop        = href_q && (lane_q == '0) && !fifo_empty;

    pcie_video_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (128),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush),
        .push_i  (push),
        .wdata_i (in_data),
        .pop_i   (pop),
        .head_o  (fifo_head),
        .count_o (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        frame_d = frame_q;
        flush   = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = RUN;
                    h_d     = '0;
                    v_d     = '0;
                end
            end
            RUN: begin
                if (h_q == H_LAST) begin
                    h_d = '0;
                    v_d = (v_q == V_LAST) ? '0 : v_q + V_W'(1);
                end else begin
                    h_d = h_q + H_W'(1);
                end
                // enable is only honoured at the frame boundary so a frame is never truncated
                if (h_q == H_LAST && v_q == V_LAST) begin
                    frame_d = frame_q + 16'd1;
                    if (!enable) begin
                        state_d = IDLE;
                        flush   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        vsync_d = (state_d == RUN) && (v_d < V_VS_END);
        href_d  = (state_d == RUN) && (v_d >= V_ACT_START) && (h_d < H_ACT_END);
    end

    always_comb begin
        lane_d  = lane_q;
        shift_d = shift_q;
        fill_d  = fill_q;
        under_d = under_q;
        if (href_q) begin
            lane_d = lane_q + LANE_W'(1);
            if (lane_q == '0) begin
                if (fifo_empty) begin
                    fill_d  = 1'b1;
                    under_d = (under_q == 16'hFFFF) ? under_q : under_q + 16'd1;
                end else begin
                    fill_d  = 1'b0;
                    shift_d = {16'h0000, fifo_head[127:16]};
                end
            end else begin
                shift_d = {16'h0000, shift_q[127:16]};
            end
        end
    end

    always_comb begin
        data_out = 16'h0000;
        if (href_q) begin
            if (lane_q == '0) data_out = fifo_empty ? FILL : fifo_head[15:0];
            else              data_out = fill_q ? FILL : shift_q[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            h_q     <= '0;
            v_q     <= '0;
            frame_q <= '0;
            under_q <= '0;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            lane_q  <= '0;
            shift_q <= '0;
            fill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
            frame_q <= frame_d;
            under_q <= under_d;
            vsync_q <= vsync_d;
            href_q  <= href_d;
            lane_q  <= lane_d;
            shift_q <= shift_d;
            fill_q  <= fill_d;
        end
    end

    assign vsync_out    = vsync_q;
    assign href_out     = href_q;
    assign de_out       = href_q;
    assign underrun_cnt = under_q;
    assign frame_cnt    = frame_q;
    assign busy         = (state_q == RUN);

endmodule

// File: tb/tb_pcie_video_unpack.sv
// tb/tb_pcie_video_unpack.sv - directed self-checking bench for pcie_video_unpack with a 20x5 raster
module tb_pcie_video_unpack;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         vsync_out;
    logic         href_out;
    logic         de_out;
    logic [15:0]  data_out;
    logic [15:0]  underrun_cnt;
    logic [15:0]  frame_cnt;
    logic         busy;

    int passed = 0;
    int total_checks = 0;
    int cyc;
    int pix;
    int sent;
    int fill_until;

    always #5 clk = ~clk;

    pcie_video_unpack #(
        .H_ACTIVE   (16),
        .H_BLANK    (4),
        .V_ACTIVE   (2),
        .V_BLANK    (3),
        .VS_LINES   (1),
        .FIFO_DEPTH (4),
        .FILL       (16'hCCCC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .vsync_out    (vsync_out),
        .href_out     (href_out),
        .de_out       (de_out),
        .data_out     (data_out),
        .underrun_cnt (underrun_cnt),
        .frame_cnt    (frame_cnt),
        .busy         (busy)
    );

    // Word n carries pixels 8n..8n+7, first pixel in the low lane.
    function automatic logic [127:0] mk(input int n);
        logic [127:0] w;
        for (int j = 0; j < 8; j++) w[16*j +: 16] = 16'(8 * n + j);
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    endtask

    task automatic step();
        logic acc;
        acc = in_valid && in_ready;
        @(posedge clk);
        #1;
        if (acc) begin
            sent++;
            in_data = mk(sent);
        end
        cyc++;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_vsync"}, vsync_out, 0);
        chk({tag, "_href"}, href_out, 0);
        chk({tag, "_de"}, de_out, 0);
        chk({tag, "_data"}, data_out, 0);
        chk({tag, "_underrun"}, underrun_cnt, 0);
        chk({tag, "_frame"}, frame_cnt, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_fifo_count"}, 32'(dut.fifo_count), 0);
    endtask

    // Raster for cycles 0..99 of RUN: 20 cycles per line, line 0 vsync, lines 3-4 active for h 0..15.
    task automatic check_cycle();
        int line;
        int h;
        logic e_vs;
        logic e_hr;
        logic [15:0] e_d;
        line = cyc / 20;
        h    = cyc % 20;
        e_vs = (line < 1);
        e_hr = (line >= 3) && (line < 5) && (h < 16);
        e_d  = 16'h0000;
        if (e_hr) begin
            if (cyc < fill_until) begin
                e_d = 16'hCCCC;
            end else begin
                e_d = 16'(pix);
                pix++;
            end
        end
        chk("vsync", vsync_out, e_vs);
        chk("href", href_out, e_hr);
        chk("de", de_out, e_hr);
        chk("data", data_out, e_d);
    endtask

    task automatic start_run(input logic valid, input int fill_limit);
        rst      = 1'b1;
        enable   = 1'b0;
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        in_valid   = valid;
        sent       = 0;
        in_data    = mk(0);
        pix        = 0;
        fill_until = fill_limit;
        enable     = 1'b1;
        cyc        = -1;
        step();
    endtask

    initial begin
        rst        = 1'b1;
        enable     = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        cyc        = 0;
        sent       = 0;
        pix        = 0;
        fill_until = 0;
        step();
        step();
        check_zero("reset");
        rst = 1'b0;
        step();
        check_zero("idle");

        // Streaming frame: prefetch, back-pressure, pixel order and frame count.
        start_run(1'b1, 0);
        chk("busy_after_enable", busy, 1);
        for (int i = 0; i < 100; i++) begin
            check_cycle();
            if (cyc <= 3) chk("in_ready_prefetch", in_ready, 1);
            if (cyc == 4) chk("in_ready_full", in_ready, 0);
            if (cyc == 59) chk("in_ready_before_pop", in_ready, 0);
            if (cyc == 61) chk("in_ready_after_pop", in_ready, 1);
            if (cyc == 62) chk("in_ready_refilled", in_ready, 0);
            step();
        end
        chk("frame_cnt_end", frame_cnt, 1);
        chk("underrun_none", underrun_cnt, 0);
        chk("vsync_next_frame", vsync_out, 1);
        chk("busy_next_frame", busy, 1);

        // Starved frame: every slot is filled.
        start_run(1'b0, 1000);
        for (int i = 0; i < 100; i++) begin
            check_cycle();
            if (cyc == 61) chk("underrun_first_slot", underrun_cnt, 1);
            if (cyc <= 3) chk("in_ready_starved", in_ready, 1);
            step();
        end
        chk("underrun_frame", underrun_cnt, 4);
        chk("frame_cnt_starved", frame_cnt, 1);

        // One starved slot, then data arrives: the next slot pops word 0.
        start_run(1'b0, 68);
        for (int i = 0; i < 100; i++) begin
            check_cycle();
            if (cyc == 62) in_valid = 1'b1;
            step();
        end
        chk("underrun_single", underrun_cnt, 1);

        // enable dropped mid-frame: frame completes then returns to IDLE with FIFO flushed.
        start_run(1'b1, 0);
        for (int i = 0; i < 100; i++) begin
            check_cycle();
            if (cyc == 70) enable = 1'b0;
            if (cyc == 99) chk("busy_last_cycle", busy, 1);
            step();
        end
        step();
        chk("busy_after_exit", busy, 0);
        chk("in_ready_after_exit", in_ready, 0);
        chk("fifo_flushed", 32'(dut.fifo_count), 0);
        chk("frame_cnt_exit", frame_cnt, 1);
        chk("vsync_after_exit", vsync_out, 0);

        // rst mid-frame during an active burst.
        start_run(1'b1, 0);
        for (int i = 0; i < 70; i++) begin
            check_cycle();
            step();
        end
        chk("de_before_rst", de_out, 1);
        enable = 1'b0;
        rst    = 1'b1;
        step();
        check_zero("mid_rst");
        rst = 1'b0;
        step();
        chk("busy_after_rst", busy, 0);

        $display("%0d/%0d checks passed", passed, total_checks);
        $finish;
    end

endmodule
